// File: rtl/spi_reg_responder_pkg.sv
// spi_reg_responder_pkg
//   Shared frame geometry and FSM state encoding for the SPI register
//   responder (spi_reg_responder) and its input synchroniser.
package spi_reg_responder_pkg;

   localparam int CMD_BITS    = 8;
   localparam int DATA_BITS   = 32;
   localparam int ADDR_BITS   = 7;
   localparam int RD_FLAG_BIT = 7;
   localparam int CNT_BITS    = $clog2(DATA_BITS + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/spi_reg_responder_sync.sv
// spi_input_sync
//   Multi-flop synchroniser for one asynchronous SPI line, followed by a
//   history flop for edge detection. All flops preset to IDLE_VAL so that
//   leaving reset does not fabricate an edge on an idle bus.
// Ports:
//   s_axi_aclk    in   system clock
//   s_axi_aresetn in   synchronous reset, active low
//   din           in   asynchronous line
//   level         out  synchronised level
//   rise / fall   out  single-cycle edge flags
module spi_input_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic IDLE_VAL    = 1'b0
) (
   input  logic s_axi_aclk,
   input  logic s_axi_aresetn,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         sync_q <= {SYNC_STAGES{IDLE_VAL}};
         hist_q <= IDLE_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_responder.sv
// spi_reg_responder
//   SPI mode-0 target, MSB first. Frame = command byte (bit7 = read,
//   bits6:0 = address) then 32 data bits. SCK/CSB/MOSI are oversampled in
//   the s_axi_aclk domain and decoded into one-cycle register strobes.
//   Build option: SPI_REG_RESPONDER_BURST_EN makes the data phase repeat
//   word after word with an auto-incrementing (wrapping) address.
// Ports:
//   s_axi_aclk, s_axi_aresetn  clock, synchronous active-low reset
//   SCK, CSB, MOSI             asynchronous SPI inputs
//   MISO                       serial read data
//   reg_addr                   address of the current frame / word
//   reg_wdata, reg_wstrobe     write data and one-cycle write pulse
//   reg_rstrobe                one-cycle read request
//   reg_rdata                  read data, sampled 1 cycle after reg_rstrobe
//
// state | meaning
// IDLE  | bus deselected, waiting for CSB fall
// CMD   | shifting in the command byte
// DATA  | shifting data in (RX) and out (TX)
// DONE  | word complete, extra SCK edges ignored, MISO held 0
module spi_reg_responder
   import spi_reg_responder_pkg::*;
#(
   parameter int    SYNC_STAGES = 2,
   parameter string DEBUG       = "false"
) (
   input  logic                 s_axi_aclk,
   input  logic                 s_axi_aresetn,
   (* MARK_DEBUG = DEBUG *) input  logic SCK,
   (* MARK_DEBUG = DEBUG *) input  logic CSB,
   (* MARK_DEBUG = DEBUG *) input  logic MOSI,
   (* MARK_DEBUG = DEBUG *) output logic MISO,
   output logic [ADDR_BITS-1:0] reg_addr,
   output logic [DATA_BITS-1:0] reg_wdata,
   output logic                 reg_wstrobe,
   output logic                 reg_rstrobe,
   input  logic [DATA_BITS-1:0] reg_rdata
);

   logic sck_rise, sck_fall, sck_s_unused;
   logic csb_rise, csb_fall, csb_s_unused;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sck (
      .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn), .din(SCK),
      .level(sck_s_unused), .rise(sck_rise), .fall(sck_fall)
   );

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_csb (
      .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn), .din(CSB),
      .level(csb_s_unused), .rise(csb_rise), .fall(csb_fall)
   );

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
      .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn), .din(MOSI),
      .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   (* MARK_DEBUG = DEBUG *) logic [1:0] state;
   logic [CNT_BITS-1:0]    bit_cnt;
   logic [CMD_BITS-2:0]    cmd_q;
   logic [DATA_BITS-2:0]   rx_q;
   logic [DATA_BITS-1:0]   tx_q;
   logic                   is_rd;
   logic                   rd_cap;

   // Shift registers hold all but the newest bit; the bit arriving on the
   // completing rise is appended here so the full word is usable that cycle.
   logic [CMD_BITS-1:0]  cmd_next;
   logic [DATA_BITS-1:0] rx_next;
   assign cmd_next = {cmd_q, mosi_s};
   assign rx_next  = {rx_q, mosi_s};

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         cmd_q       <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         is_rd       <= 1'b0;
         rd_cap      <= 1'b0;
         MISO        <= 1'b0;
         reg_addr    <= '0;
         reg_wdata   <= '0;
         reg_wstrobe <= 1'b0;
         reg_rstrobe <= 1'b0;
      end else begin
         reg_wstrobe <= 1'b0;
         reg_rstrobe <= 1'b0;
         // Read data is valid the cycle after the strobe; load it then.
         rd_cap      <= reg_rstrobe;
         if (rd_cap)
            tx_q <= reg_rdata;
`ifdef SPI_REG_RESPONDER_BURST_EN
         // Advance after the write strobe so the strobe still carries
         // the address of the word just written.
         if (reg_wstrobe)
            reg_addr <= reg_addr + 1'b1;
`endif
         // CSB events take priority and swallow any coincident SCK edge.
         if (csb_rise) begin
            state <= ST_IDLE;
            MISO  <= 1'b0;
         end else if (csb_fall) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
            MISO    <= 1'b0;
         end else begin
            case (state)
               ST_CMD: begin
                  if (sck_rise) begin
                     cmd_q <= cmd_next[CMD_BITS-2:0];
                     if (bit_cnt == CNT_BITS'(CMD_BITS - 1)) begin
                        reg_addr    <= cmd_next[ADDR_BITS-1:0];
                        is_rd       <= cmd_next[RD_FLAG_BIT];
                        reg_rstrobe <= cmd_next[RD_FLAG_BIT];
                        bit_cnt     <= '0;
                        state       <= ST_DATA;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
               ST_DATA: begin
                  if (sck_rise) begin
                     rx_q <= rx_next[DATA_BITS-2:0];
                     if (bit_cnt == CNT_BITS'(DATA_BITS - 1)) begin
                        bit_cnt <= '0;
                        if (!is_rd) begin
                           reg_wdata   <= rx_next;
                           reg_wstrobe <= 1'b1;
                        end
`ifdef SPI_REG_RESPONDER_BURST_EN
                        if (is_rd) begin
                           reg_addr    <= reg_addr + 1'b1;
                           reg_rstrobe <= 1'b1;
                        end
`else
                        state <= ST_DONE;
`endif
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else if (sck_fall) begin
                     if (is_rd)
                        MISO <= tx_q[DATA_BITS-1];
                     tx_q <= {tx_q[DATA_BITS-2:0], 1'b0};
                  end
               end
               ST_DONE: MISO <= 1'b0;
               default: ;
            endcase
         end
      end
   end

endmodule
